// File: rtl/stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch
// Description : M:SS BCD stopwatch with start/stop, cancel and an optional
//               lap hold (compiled in when STOPWATCH_LAP_HOLD_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch #(
  parameter int PRESCALE = 100000000,
  parameter int MAX_MINS = 9
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       s_start_stop,
  input  logic       s_lap,
  input  logic       s_cancel,
  output logic [3:0] secs,
  output logic [3:0] ten_secs,
  output logic [3:0] mins,
  output logic       running,
  output logic       overflow
);

  localparam int              c_pw        = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pw-1:0] c_presc_top = c_pw'(PRESCALE - 1);
  localparam logic [3:0]      c_max_mins  = 4'(MAX_MINS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_pw-1:0] r_presc;
  logic [c_pw-1:0] w_presc_nxt;
  logic [3:0]      r_secs;
  logic [3:0]      r_tens;
  logic [3:0]      r_mins;
  logic [3:0]      w_secs_nxt;
  logic [3:0]      w_tens_nxt;
  logic [3:0]      w_mins_nxt;
  logic            w_at_max;
  logic            w_full_evt;
  logic [3:0]      w_disp_secs;
  logic [3:0]      w_disp_tens;
  logic [3:0]      w_disp_mins;

  assign w_at_max = (r_mins == c_max_mins) && (r_tens == 4'd5) && (r_secs == 4'd9);

  // Tick is evaluated first so it still lands on a cycle where start/stop pauses.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_secs_nxt  = r_secs;
    w_tens_nxt  = r_tens;
    w_mins_nxt  = r_mins;
    w_full_evt  = 1'b0;

    if (r_state == S_RUNNING) begin
      if (r_presc == c_presc_top) begin
        w_presc_nxt = '0;
        if (w_at_max) begin
          w_full_evt = 1'b1;
        end else if (r_secs != 4'd9) begin
          w_secs_nxt = r_secs + 4'd1;
        end else begin
          w_secs_nxt = 4'd0;
          if (r_tens != 4'd5) begin
            w_tens_nxt = r_tens + 4'd1;
          end else begin
            w_tens_nxt = 4'd0;
            w_mins_nxt = r_mins + 4'd1;
          end
        end
      end else begin
        w_presc_nxt = r_presc + 1'b1;
      end
    end

    if (s_cancel) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_secs_nxt  = 4'd0;
      w_tens_nxt  = 4'd0;
      w_mins_nxt  = 4'd0;
    end else if (s_start_stop) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_RUNNING;
          w_presc_nxt = '0;
        end
        S_RUNNING: w_state_nxt = S_PAUSED;
        S_PAUSED:  w_state_nxt = S_RUNNING;
        default:   w_state_nxt = r_state;
      endcase
    end else if (w_full_evt) begin
      w_state_nxt = S_FULL;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       r_hold_on;
  logic [3:0] r_hold_secs;
  logic [3:0] r_hold_tens;
  logic [3:0] r_hold_mins;
  logic       w_hold_on_nxt;
  logic [3:0] w_hold_secs_nxt;
  logic [3:0] w_hold_tens_nxt;
  logic [3:0] w_hold_mins_nxt;

  always_comb begin
    w_hold_on_nxt   = r_hold_on;
    w_hold_secs_nxt = r_hold_secs;
    w_hold_tens_nxt = r_hold_tens;
    w_hold_mins_nxt = r_hold_mins;
    if (s_cancel) begin
      w_hold_on_nxt   = 1'b0;
      w_hold_secs_nxt = 4'd0;
      w_hold_tens_nxt = 4'd0;
      w_hold_mins_nxt = 4'd0;
    end else begin
      if (!s_start_stop && s_lap) begin
        if (r_hold_on) begin
          w_hold_on_nxt = 1'b0;
        end else if (r_state == S_RUNNING || r_state == S_PAUSED) begin
          w_hold_on_nxt   = 1'b1;
          w_hold_secs_nxt = r_secs;
          w_hold_tens_nxt = r_tens;
          w_hold_mins_nxt = r_mins;
        end
      end
      if (w_state_nxt == S_FULL && r_state != S_FULL) begin
        w_hold_on_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hold_on   <= 1'b0;
      r_hold_secs <= 4'd0;
      r_hold_tens <= 4'd0;
      r_hold_mins <= 4'd0;
    end else begin
      r_hold_on   <= w_hold_on_nxt;
      r_hold_secs <= w_hold_secs_nxt;
      r_hold_tens <= w_hold_tens_nxt;
      r_hold_mins <= w_hold_mins_nxt;
    end
  end

  assign w_disp_secs = w_hold_on_nxt ? w_hold_secs_nxt : w_secs_nxt;
  assign w_disp_tens = w_hold_on_nxt ? w_hold_tens_nxt : w_tens_nxt;
  assign w_disp_mins = w_hold_on_nxt ? w_hold_mins_nxt : w_mins_nxt;
`else
  logic w_unused_lap;
  assign w_unused_lap = s_lap;

  assign w_disp_secs = w_secs_nxt;
  assign w_disp_tens = w_tens_nxt;
  assign w_disp_mins = w_mins_nxt;
`endif

  // Outputs are registered from next-state values so they change on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_secs   <= 4'd0;
      r_tens   <= 4'd0;
      r_mins   <= 4'd0;
      secs     <= 4'd0;
      ten_secs <= 4'd0;
      mins     <= 4'd0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_secs   <= w_secs_nxt;
      r_tens   <= w_tens_nxt;
      r_mins   <= w_mins_nxt;
      secs     <= w_disp_secs;
      ten_secs <= w_disp_tens;
      mins     <= w_disp_mins;
      running  <= (w_state_nxt == S_RUNNING);
      overflow <= (w_state_nxt == S_FULL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch
// Description : Directed and random checks of stopwatch against a
//               seconds-count reference model (PRESCALE=4, MAX_MINS=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch;

  localparam int P    = 4;
  localparam int MM   = 1;
  localparam int MAXT = MM * 60 + 59;
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FULL = 3;

  logic       CLK;
  logic       RESET;
  logic       s_start_stop;
  logic       s_lap;
  logic       s_cancel;
  logic [3:0] secs;
  logic [3:0] ten_secs;
  logic [3:0] mins;
  logic       running;
  logic       overflow;

  int n_total = 0;
  int n_bad   = 0;

  int m_mode, m_phase, m_t, m_hold_t;
  bit m_hold_on;

  stopwatch #(.PRESCALE(P), .MAX_MINS(MM)) dut (
    .CLK(CLK), .RESET(RESET), .s_start_stop(s_start_stop), .s_lap(s_lap),
    .s_cancel(s_cancel), .secs(secs), .ten_secs(ten_secs), .mins(mins),
    .running(running), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int t);
    return 32'(((t / 60) << 8) | (((t % 60) / 10) << 4) | (t % 10));
  endfunction

  function automatic logic [31:0] disp();
    return {20'd0, mins, ten_secs, secs};
  endfunction

  task automatic model(input bit rst, input bit ss, input bit lp, input bit cn);
    int  old_mode, old_t;
    bit  full_evt;
    if (rst || cn) begin
      m_mode = M_IDLE; m_phase = 0; m_t = 0; m_hold_on = 0; m_hold_t = 0;
      return;
    end
    old_mode = m_mode;
    old_t    = m_t;
    full_evt = 0;
    if (old_mode == M_RUN) begin
      if (m_phase == P - 1) begin
        if (m_t == MAXT) full_evt = 1;
        else m_t++;
      end
      m_phase = (m_phase + 1) % P;
    end
    if (ss) begin
      if (old_mode == M_IDLE) begin
        m_mode = M_RUN; m_phase = 0;
      end else if (old_mode == M_RUN) m_mode = M_PAUSE;
      else if (old_mode == M_PAUSE) m_mode = M_RUN;
    end else if (full_evt) begin
      m_mode = M_FULL;
    end
    if (LAP && !ss && lp) begin
      if (m_hold_on) m_hold_on = 0;
      else if (old_mode == M_RUN || old_mode == M_PAUSE) begin
        m_hold_on = 1; m_hold_t = old_t;
      end
    end
    if (m_mode == M_FULL && old_mode != M_FULL) m_hold_on = 0;
  endtask

  task automatic step(input bit rst, input bit ss, input bit lp, input bit cn);
    RESET = rst; s_start_stop = ss; s_lap = lp; s_cancel = cn;
    @(posedge CLK);
    model(rst, ss, lp, cn);
    #1;
    RESET = 0; s_start_stop = 0; s_lap = 0; s_cancel = 0;
    check("model_disp", disp(), to_bcd(m_hold_on ? m_hold_t : m_t));
    check("model_running", {31'd0, running}, {31'd0, m_mode == M_RUN});
    check("model_overflow", {31'd0, overflow}, {31'd0, m_mode == M_FULL});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    RESET = 1; s_start_stop = 0; s_lap = 0; s_cancel = 0;
    m_mode = M_IDLE; m_phase = 0; m_t = 0; m_hold_on = 0; m_hold_t = 0;

    step(1, 0, 0, 0);
    check("reset_disp", disp(), 32'h000);
    check("reset_running", {31'd0, running}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);

    // 40 cycles at 4 cycles per second -> 10 s
    step(0, 1, 0, 0);
    idle(40);
    check("run40_disp", disp(), 32'h010);
    check("run40_running", {31'd0, running}, 32'd1);

    // run to the ceiling, then one more second saturates into FULL
    idle(436);
    check("at_max_disp", disp(), 32'h159);
    check("at_max_running", {31'd0, running}, 32'd1);
    idle(4);
    check("full_disp", disp(), 32'h159);
    check("full_overflow", {31'd0, overflow}, 32'd1);
    check("full_running", {31'd0, running}, 32'd0);
    step(0, 1, 0, 0);
    check("full_ss_ignored", {31'd0, overflow}, 32'd1);
    check("full_ss_disp", disp(), 32'h159);

    // pause/resume keeps the prescaler phase
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(5);
    check("pre_pause_disp", disp(), 32'h001);
    step(0, 1, 0, 0);
    idle(20);
    check("paused_disp", disp(), 32'h001);
    check("paused_running", {31'd0, running}, 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("resume1_disp", disp(), 32'h001);
    step(0, 0, 0, 0);
    check("resume2_disp", disp(), 32'h002);

    // cancel beats start/stop
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(148);
    check("at_037_disp", disp(), 32'h037);
    step(0, 1, 0, 1);
    check("cancel_ss_disp", disp(), 32'h000);
    check("cancel_ss_running", {31'd0, running}, 32'd0);

    // lap hold
    step(0, 1, 0, 0);
    idle(20);
    check("lap_pre_disp", disp(), 32'h005);
    step(0, 0, 1, 0);
    idle(12);
`ifdef STOPWATCH_LAP_HOLD_EN
    check("lap_held_disp", disp(), 32'h005);
    step(0, 0, 1, 0);
    check("lap_release_disp", disp(), 32'h008);
`else
    check("nolap_live_disp", disp(), 32'h008);
`endif

    // reset mid-count
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(92);
    check("at_023_disp", disp(), 32'h023);
    step(1, 1, 1, 0);
    check("rst_run_disp", disp(), 32'h000);
    check("rst_run_running", {31'd0, running}, 32'd0);
    check("rst_run_overflow", {31'd0, overflow}, 32'd0);

    // random pulses against the model
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 799) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch.md
STOPWATCH -- requirements
Module: stopwatch

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000000; CLK cycles per counted second, minimum 2.
REQ-002 SHALL have parameter MAX_MINS, default 9; highest minutes value, 1..9.
REQ-003 SHALL have port CLK  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_start_stop  input  1  single-cycle debounced press pulse; toggles counting.
REQ-006 SHALL have port s_lap  input  1  single-cycle debounced press pulse; freezes or releases the displayed time.
REQ-007 SHALL have port s_cancel  input  1  single-cycle debounced press pulse; clears the time.
REQ-008 SHALL have port secs  output  4  displayed seconds units, BCD 0..9.
REQ-009 SHALL have port ten_secs  output  4  displayed seconds tens, BCD 0..5.
REQ-010 SHALL have port mins  output  4  displayed minutes, BCD 0..MAX_MINS.
REQ-011 SHALL have port running  output  1  high while in RUNNING.
REQ-012 SHALL have port overflow  output  1  high while in FULL.

Function
REQ-013 SHALL implement four states: IDLE (time 0:00), RUNNING, PAUSED, FULL.
REQ-014 SHALL keep an internal live time (mins:ten_secs:secs) and a prescaler counter 0..PRESCALE-1.
REQ-015 In RUNNING, the prescaler SHALL increment every cycle; when it equals PRESCALE-1 it SHALL return to 0 and the live time SHALL advance one second on that same edge.
REQ-016 The seconds advance SHALL be BCD: secs 9->0 carries into ten_secs; ten_secs 5->0 carries into mins.
REQ-017 When the live time is MAX_MINS:5:9 and a second elapses, the live time SHALL stay at MAX_MINS:5:9 and the state SHALL go to FULL.
REQ-018 s_start_stop SHALL move IDLE->RUNNING, RUNNING->PAUSED and PAUSED->RUNNING; it SHALL be ignored in FULL.
REQ-019 Entering RUNNING from IDLE SHALL clear the prescaler; leaving and re-entering RUNNING from PAUSED SHALL preserve it.
REQ-020 In PAUSED, the prescaler and the live time SHALL hold.
REQ-021 s_cancel in any state SHALL clear the live time, the prescaler and the lap hold, and SHALL go to IDLE.
REQ-022 Same-cycle priority SHALL be s_cancel > s_start_stop > s_lap > second tick; the tick SHALL still apply on a cycle where s_start_stop leaves RUNNING.
REQ-023 The outputs secs, ten_secs and mins SHALL show the live time except when the lap hold is active (REQ-030).
REQ-024 running and overflow SHALL be registered, decoded from state, and valid on the first cycle of the new state.
REQ-025 Output latency: a time change SHALL appear on the outputs on the same edge that updates the live time (registered, no extra cycle).

Reset
REQ-026 On RESET high at a rising CLK edge, the block SHALL go to IDLE.
REQ-027 On reset, the live time, the prescaler and the lap hold SHALL be cleared.
REQ-028 On reset, all outputs SHALL be 0.
REQ-029 RESET SHALL override every input event, including in mid-count and in FULL.

Configuration
REQ-030 With macro STOPWATCH_LAP_HOLD_EN defined, the lap hold SHALL be compiled in:
- s_lap in RUNNING or PAUSED with hold off SHALL copy the live time into a hold register and turn hold on.
- s_lap with hold on SHALL turn hold off.
- While hold is on, the outputs SHALL show the hold register and the live time SHALL keep counting.
- Entering FULL SHALL clear hold.
REQ-031 Without STOPWATCH_LAP_HOLD_EN, s_lap SHALL be ignored, no hold register SHALL exist, and the outputs SHALL always show the live time.

Verification (PRESCALE=4, MAX_MINS=1 unless stated)
REQ-032 Bench SHALL cover:
- RESET, then s_start_stop, then 40 cycles -> outputs 0:1:0, running=1.
- Run to 1:5:9, then 4 more cycles -> outputs stay 1:5:9, overflow=1, running=0; a further s_start_stop has no effect.
- Start, 6 cycles, s_start_stop, wait 20 cycles, s_start_stop, 2 cycles -> time advances to 0:0:2 exactly 2 cycles after resume (prescaler preserved).
- s_cancel and s_start_stop asserted in the same cycle while RUNNING at 0:3:7 -> IDLE, outputs 0:0:0, running=0.
- With STOPWATCH_LAP_HOLD_EN: s_lap at 0:0:5, run 12 cycles -> outputs stay 0:0:5; second s_lap -> outputs 0:0:8.
- RESET pulse during RUNNING at 0:2:3 -> next cycle outputs 0:0:0, running=0, overflow=0.
